// File: rtl/ais_frame_sequencer.sv
// HDLC frame sequencer: finds the start flag inside the search window, destuffs and emits the payload.
// Latency: payload bits appear 8 raw strobes + 1 clock after entry; SOF/EOF/error 1 clock after the causing strobe.
// Backpressure: none; the block is paced by i_vld and every output is a registered single-cycle pulse.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_vld                raw bit strobe; i_bit / i_window are sampled only while it is high
//   i_window             flag search window, aligned with i_bit
//   i_bit                NRZI-decoded, still-stuffed raw bit
//   o_vld / o_bit        destuffed payload bit strobe and value
//   o_sof                start flag found
//   o_eof / o_len        valid end flag received, payload bit count
//   o_err_vld / o_err    error strobe, code 1 = MISS, 2 = ABORT, 3 = LONG/SHORT
//   o_busy               high while searching for or receiving a frame
module ais_frame_sequencer #(
  parameter logic [7:0] PAR_FLAG     = 8'h7E,
  parameter int         PAR_MAX_BITS = 256,
  parameter int         PAR_MIN_BITS = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_vld,
  input  logic                              i_window,
  input  logic                              i_bit,
  output logic                              o_vld,
  output logic                              o_bit,
  output logic                              o_sof,
  output logic                              o_eof,
  output logic [$clog2(PAR_MAX_BITS+1)-1:0] o_len,
  output logic [1:0]                        o_err,
  output logic                              o_err_vld,
  output logic                              o_busy
);

  localparam int LW = $clog2(PAR_MAX_BITS + 1);
  localparam logic [LW-1:0] MAX_CNT = LW'(PAR_MAX_BITS);
  localparam logic [LW-1:0] MIN_CNT = LW'(PAR_MIN_BITS);

  localparam logic [1:0] ERR_MISS  = 2'd1;
  localparam logic [1:0] ERR_ABORT = 2'd2;
  localparam logic [1:0] ERR_LEN   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RECV   = 2'd2
  } state_t;

  // Architectural state
  state_t          state_q, state_d;
  logic [7:0]      sreg_q, sreg_d;
  logic [6:0]      dl_bit_q, dl_bit_d;    // delay line data, index 6 = oldest when full
  logic [6:0]      dl_keep_q, dl_keep_d;  // 0 marks a stuffed bit to be dropped
  logic [2:0]      dl_cnt_q, dl_cnt_d;    // occupied entries, saturates at 7
  logic [2:0]      ones_q, ones_d;        // consecutive raw ones
  logic [LW-1:0]   cnt_q, cnt_d;          // destuffed payload bits emitted

  // Next values of the registered outputs
  logic            vld_d;
  logic            bit_d;
  logic            sof_d;
  logic            eof_d;
  logic [LW-1:0]   len_d;
  logic [1:0]      err_d;
  logic            err_vld_d;

  logic [7:0]      sreg_shift;
  logic            flag_hit;
  logic            abort_hit;
  logic            stuffed;

  assign sreg_shift = {sreg_q[6:0], i_bit};
  assign flag_hit   = (sreg_shift == PAR_FLAG);
  assign abort_hit  = (sreg_shift[6:0] == 7'h7F);
  // A zero directly after five ones was inserted by the transmitter.
  assign stuffed    = (ones_q == 3'd5) && !i_bit;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    dl_bit_d  = dl_bit_q;
    dl_keep_d = dl_keep_q;
    dl_cnt_d  = dl_cnt_q;
    ones_d    = ones_q;
    cnt_d     = cnt_q;
    vld_d     = 1'b0;
    bit_d     = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    len_d     = '0;
    err_d     = '0;
    err_vld_d = 1'b0;

    if (i_vld) begin
      case (state_q)
        ST_IDLE: begin
          if (i_window) begin
            state_d = ST_SEARCH;
            // Start the flag search from a clean register so stale bits cannot fake a hit.
            sreg_d  = {7'b0, i_bit};
          end
        end

        ST_SEARCH: begin
          sreg_d = sreg_shift;
          // A hit on the last window bit wins over the miss.
          if (flag_hit) begin
            state_d   = ST_RECV;
            sof_d     = 1'b1;
            dl_bit_d  = '0;
            dl_keep_d = '0;
            dl_cnt_d  = '0;
            ones_d    = '0;
            cnt_d     = '0;
          end else if (!i_window) begin
            state_d   = ST_IDLE;
            err_d     = ERR_MISS;
            err_vld_d = 1'b1;
          end
        end

        ST_RECV: begin
          sreg_d = sreg_shift;
          if (i_bit) begin
            ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
          end else begin
            ones_d = '0;
          end

          if (abort_hit) begin
            state_d   = ST_IDLE;
            err_d     = ERR_ABORT;
            err_vld_d = 1'b1;
          end else if (flag_hit) begin
            if (cnt_q == '0) begin
              // Repeated opening flag: drop the flag bits already queued and keep listening.
              dl_bit_d  = '0;
              dl_keep_d = '0;
              dl_cnt_d  = '0;
            end else begin
              // The 7 queued entries are the end flag itself and are discarded.
              state_d = ST_IDLE;
              if (cnt_q >= MIN_CNT) begin
                eof_d = 1'b1;
                len_d = cnt_q;
              end else begin
                err_d     = ERR_LEN;
                err_vld_d = 1'b1;
              end
            end
          end else begin
            dl_bit_d  = {dl_bit_q[5:0], i_bit};
            dl_keep_d = {dl_keep_q[5:0], !stuffed};
            if (dl_cnt_q != 3'd7) begin
              dl_cnt_d = dl_cnt_q + 3'd1;
            end else if (dl_keep_q[6]) begin
              if (cnt_q == MAX_CNT) begin
                // Overlong frame: the bit that would exceed the limit is not emitted.
                state_d   = ST_IDLE;
                err_d     = ERR_LEN;
                err_vld_d = 1'b1;
              end else begin
                vld_d = 1'b1;
                bit_d = dl_bit_q[6];
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      dl_bit_q  <= '0;
      dl_keep_q <= '0;
      dl_cnt_q  <= '0;
      ones_q    <= '0;
      cnt_q     <= '0;
      o_vld     <= 1'b0;
      o_bit     <= 1'b0;
      o_sof     <= 1'b0;
      o_eof     <= 1'b0;
      o_len     <= '0;
      o_err     <= '0;
      o_err_vld <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      dl_bit_q  <= dl_bit_d;
      dl_keep_q <= dl_keep_d;
      dl_cnt_q  <= dl_cnt_d;
      ones_q    <= ones_d;
      cnt_q     <= cnt_d;
      o_vld     <= vld_d;
      o_bit     <= bit_d;
      o_sof     <= sof_d;
      o_eof     <= eof_d;
      o_len     <= len_d;
      o_err     <= err_d;
      o_err_vld <= err_vld_d;
    end
  end

  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ais_frame_sequencer.sv
// Testbench for ais_frame_sequencer: frame-level reference (HDLC stuffer plus expected outcome rules).
// Stimulus is paced by i_vld with random idle gaps and junk inputs while i_vld is low.
// Outputs are sampled #1 after the rising edge or on the falling edge by a monitor.
module tb_ais_frame_sequencer;

  localparam int MAX_BITS = 256;
  localparam int MIN_BITS = 16;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_vld;
  logic       i_window;
  logic       i_bit;
  logic       o_vld;
  logic       o_bit;
  logic       o_sof;
  logic       o_eof;
  logic [8:0] o_len;
  logic [1:0] o_err;
  logic       o_err_vld;
  logic       o_busy;

  ais_frame_sequencer dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_vld     (i_vld),
    .i_window  (i_window),
    .i_bit     (i_bit),
    .o_vld     (o_vld),
    .o_bit     (o_bit),
    .o_sof     (o_sof),
    .o_eof     (o_eof),
    .o_len     (o_len),
    .o_err     (o_err),
    .o_err_vld (o_err_vld),
    .o_busy    (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit pay_q[$];   // intended payload (destuffed)
  bit tx_q[$];    // stuffed payload as sent on the wire
  bit rx_q[$];    // payload bits observed on o_vld

  int         sof_cnt, eof_cnt, err_cnt;
  logic [8:0] last_len;
  logic [1:0] last_err;

  always @(negedge i_clk) begin
    if (o_vld) rx_q.push_back(o_bit);
    if (o_sof) sof_cnt++;
    if (o_eof) begin eof_cnt++; last_len = o_len; end
    if (o_err_vld) begin err_cnt++; last_err = o_err; end
  end

  task automatic clear_mon();
    rx_q.delete();
    sof_cnt = 0; eof_cnt = 0; err_cnt = 0;
    last_len = '0; last_err = '0;
  endtask

  // Entered and left at rising edge + 1.
  task automatic send_bit(input bit b, input bit w);
    i_vld = 1'b1; i_bit = b; i_window = w;
    @(posedge i_clk); #1;
    i_vld = 1'b0; i_bit = 1'($urandom); i_window = 1'($urandom);
  endtask

  task automatic idle_cycle();
    @(posedge i_clk); #1;
  endtask

  task automatic send_flag(input bit w);
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 7; i >= 0; i--) send_bit(f[i], w);
  endtask

  task automatic send_tx(input bit w);
    foreach (tx_q[i]) begin
      send_bit(tx_q[i], w);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
  endtask

  // HDLC transmit-side zero insertion after five consecutive ones.
  task automatic stuff_payload();
    int ones;
    ones = 0;
    tx_q.delete();
    foreach (pay_q[i]) begin
      tx_q.push_back(pay_q[i]);
      ones = pay_q[i] ? ones + 1 : 0;
      if (ones == 5) begin tx_q.push_back(1'b0); ones = 0; end
    end
  endtask

  task automatic rand_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(1'($urandom));
  endtask

  // Sends 0000 + nflags flags (window open on the first one) + stuffed payload + flag,
  // then checks the observed frame against the length rules.
  task automatic run_frame(input string name, input int nflags);
    int n, exp_vld, nbad;
    bit exp_eof, exp_err;
    clear_mon();
    stuff_payload();
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    send_flag(1'b1);
    for (int i = 1; i < nflags; i++) send_flag(1'b0);
    send_tx(1'b0);
    send_flag(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);

    n = pay_q.size();
    if (n > MAX_BITS) begin
      exp_vld = MAX_BITS; exp_eof = 1'b0; exp_err = 1'b1;
    end else if (n < MIN_BITS) begin
      exp_vld = n; exp_eof = 1'b0; exp_err = 1'b1;
    end else begin
      exp_vld = n; exp_eof = 1'b1; exp_err = 1'b0;
    end

    n_tests++;
    if (sof_cnt !== 1) begin
      n_fail++; $display("FAIL %s sof_count: got %0d want 1", name, sof_cnt);
    end
    n_tests++;
    if (rx_q.size() !== exp_vld) begin
      n_fail++; $display("FAIL %s vld_count: got %0d want %0d", name, rx_q.size(), exp_vld);
    end
    nbad = 0;
    for (int i = 0; i < exp_vld && i < rx_q.size(); i++)
      if (rx_q[i] !== pay_q[i]) nbad++;
    n_tests++;
    if (nbad !== 0) begin
      n_fail++; $display("FAIL %s payload_bits: got %0d wrong bits want 0", name, nbad);
    end
    n_tests++;
    if (eof_cnt !== int'(exp_eof)) begin
      n_fail++; $display("FAIL %s eof_count: got %0d want %0d", name, eof_cnt, exp_eof);
    end
    if (exp_eof) begin
      n_tests++;
      if (last_len !== 9'(n)) begin
        n_fail++; $display("FAIL %s o_len: got %0d want %0d", name, last_len, n);
      end
    end
    n_tests++;
    if (err_cnt !== int'(exp_err)) begin
      n_fail++; $display("FAIL %s err_count: got %0d want %0d", name, err_cnt, exp_err);
    end
    if (exp_err) begin
      n_tests++;
      if (last_err !== 2'd3) begin
        n_fail++; $display("FAIL %s err_code: got %0d want 3", name, last_err);
      end
    end
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_after: got %0b want 0", name, o_busy);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_vld = 1'b0; i_bit = 1'b0; i_window = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_tests++;
    if ({o_vld, o_bit, o_sof, o_eof, o_len, o_err, o_err_vld, o_busy} !== 17'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0",
                         {o_vld, o_bit, o_sof, o_eof, o_len, o_err, o_err_vld, o_busy});
    end
    i_rst_n = 1'b1;
    idle_cycle();
    idle_cycle();
    n_tests++;
    if ({o_vld, o_sof, o_eof, o_err_vld, o_busy} !== 5'd0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b want 00000",
                         {o_vld, o_sof, o_eof, o_err_vld, o_busy});
    end
  endtask

  task automatic test_basic_frame();
    logic [15:0] d;
    d = 16'hA5C3;
    pay_q.delete();
    for (int i = 15; i >= 0; i--) pay_q.push_back(d[i]);
    run_frame("basic_a5c3", 1);
  endtask

  task automatic test_stuffing();
    logic [7:0] d;
    d = 8'hF8;
    pay_q.delete();
    for (int i = 7; i >= 0; i--) pay_q.push_back(d[i]);
    for (int i = 0; i < 16; i++) pay_q.push_back(1'($urandom));
    run_frame("stuff_f8", 1);
    pay_q.delete();
    for (int i = 0; i < 40; i++) pay_q.push_back(1'b1);   // dense stuffing
    run_frame("stuff_ones", 1);
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 6; k++) begin
      rand_payload($urandom_range(MIN_BITS, 96));
      run_frame("random_frame", 1);
    end
  endtask

  task automatic test_miss();
    clear_mon();
    for (int i = 0; i < 24; i++) begin
      send_bit((i % 5 == 4) ? 1'b0 : 1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    n_tests++;
    if (err_cnt !== 0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL miss_in_window: got err_cnt=%0d busy=%0b want 0 and 1", err_cnt, o_busy);
    end
    send_bit(1'b0, 1'b0);
    n_tests++;
    if ({o_err_vld, o_err} !== 3'b101) begin
      n_fail++; $display("FAIL miss_strobe: got vld=%0b code=%0d want vld=1 code=1", o_err_vld, o_err);
    end
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL miss_busy: got %0b want 0", o_busy);
    end
    send_bit(1'b0, 1'b0);
    idle_cycle();
    n_tests++;
    if (err_cnt !== 1 || sof_cnt !== 0) begin
      n_fail++; $display("FAIL miss_once: got err_cnt=%0d sof_cnt=%0d want 1 and 0", err_cnt, sof_cnt);
    end
  endtask

  task automatic test_abort();
    int nbad;
    clear_mon();
    pay_q.delete();
    for (int i = 0; i < 8; i++) pay_q.push_back((i == 3 || i == 7) ? 1'b0 : 1'($urandom));
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    send_flag(1'b1);
    foreach (pay_q[i]) send_bit(pay_q[i], 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    n_tests++;
    if ({o_err_vld, o_err} !== 3'b110) begin
      n_fail++; $display("FAIL abort_strobe: got vld=%0b code=%0d want vld=1 code=2", o_err_vld, o_err);
    end
    for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1'b0);
    idle_cycle();
    // 14 entries pushed before the abort, so the first 7 data bits left the delay line.
    n_tests++;
    if (rx_q.size() !== 7) begin
      n_fail++; $display("FAIL abort_vld_count: got %0d want 7", rx_q.size());
    end
    nbad = 0;
    for (int i = 0; i < 7 && i < rx_q.size(); i++) if (rx_q[i] !== pay_q[i]) nbad++;
    n_tests++;
    if (nbad !== 0 || eof_cnt !== 0 || err_cnt !== 1) begin
      n_fail++; $display("FAIL abort_after: got bad=%0d eof=%0d err=%0d want 0 0 1", nbad, eof_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    rand_payload(16);
    run_frame("back_to_back", 2);
    rand_payload(20);
    run_frame("triple_flag", 3);
  endtask

  task automatic test_length_limits();
    rand_payload(8);
    run_frame("short_8", 1);
    rand_payload(MIN_BITS - 1);
    run_frame("short_15", 1);
    rand_payload(MIN_BITS);
    run_frame("min_16", 1);
    rand_payload(MAX_BITS);
    run_frame("max_256", 1);
    rand_payload(MAX_BITS + 1);
    run_frame("long_257", 1);
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    rand_payload(40);
    stuff_payload();
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    send_flag(1'b1);
    for (int i = 0; i < 20; i++) send_bit(tx_q[i], 1'b0);
    n_tests++;
    if (o_busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_busy_before: got %0b want 1", o_busy);
    end
    #1 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_vld, o_bit, o_sof, o_eof, o_len, o_err, o_err_vld, o_busy} !== 17'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h want 0",
                         {o_vld, o_bit, o_sof, o_eof, o_len, o_err, o_err_vld, o_busy});
    end
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    idle_cycle();
    idle_cycle();
    n_tests++;
    if (eof_cnt !== 0 || err_cnt !== 0) begin
      n_fail++; $display("FAIL midrst_no_pulse: got eof=%0d err=%0d want 0 0", eof_cnt, err_cnt);
    end
    rand_payload(32);
    run_frame("post_midrst", 1);
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic_frame();
    test_stuffing();
    test_random_frames();
    test_miss();
    test_abort();
    test_back_to_back();
    test_length_limits();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ais_frame_sequencer.md
Name: ais_frame_sequencer

Overview:
- Controls frame reception after the flag search window.
- Consumes the per-bit search window and the NRZI-decoded raw bit stream.
- Finds the HDLC start flag (0x7E) inside the window, then receives the frame: removes stuffed bits, strips the end flag, checks length and abort conditions.
- Emits destuffed payload bits plus SOF/EOF/error strobes to the downstream CRC/packing stage.

Parameters:
- PAR_FLAG, 8'h7E: flag pattern, compared MSB = oldest bit.
- PAR_MAX_BITS, 256: maximum destuffed payload bits (data + CRC) allowed before the end flag.
- PAR_MIN_BITS, 16: minimum destuffed bits required for a valid EOF.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_vld, input, 1: bit strobe; i_bit and i_window are sampled only when it is high.
- i_window, input, 1: flag search window, aligned with i_bit.
- i_bit, input, 1: raw (stuffed) decoded bit.
- o_vld, output, 1: o_bit is a valid destuffed payload bit (1-cycle pulse).
- o_bit, output, 1: destuffed payload bit.
- o_sof, output, 1: start flag found (1-cycle pulse).
- o_eof, output, 1: valid end flag received (1-cycle pulse).
- o_len, output, log2(PAR_MAX_BITS+1): payload bit count; valid while o_eof is high.
- o_err, output, 2: error code, valid while o_err_vld is high. 1 = MISS, 2 = ABORT, 3 = LONG/SHORT.
- o_err_vld, output, 1: error strobe (1-cycle pulse).
- o_busy, output, 1: high in the SEARCH and RECV states.

Behaviour:
- Reset (asynchronous, i_rst_n = 0):
  - State = IDLE.
  - All outputs 0.
  - Shift register, delay line, ones counter and bit counter cleared.
- All state updates occur only on cycles with i_vld = 1.
- Outputs are registered: each is asserted the cycle after the i_vld cycle that caused it. Pulse outputs are low otherwise.
- Internal 8-bit raw shift register: sreg_next = {sreg[6:0], i_bit}. Flag hit = (sreg_next == PAR_FLAG).
- IDLE:
  - i_window = 1 → SEARCH, with sreg cleared and the current bit shifted in.
- SEARCH:
  - Flag hit → RECV. o_sof = 1. Delay line, ones counter and bit counter cleared.
  - Otherwise, i_window = 0 → IDLE with o_err = MISS.
  - Flag hit on the last window bit takes priority over MISS.
- RECV, per raw bit:
  - Ones counter: increments on 1, clears on 0.
  - Stuffed bit: ones == 5 and i_bit = 0 (before update). The bit is pushed to the delay line with keep = 0.
  - Abort: sreg_next[6:0] == 7'h7F (7 consecutive ones) → IDLE with o_err = ABORT. No EOF.
  - Flag hit, bit counter == 0 (back-to-back flag): re-sync. Stay in RECV, delay line cleared. No o_sof, no o_eof.
  - Flag hit, bit counter > 0:
    - Current bit is not pushed; the delay line (7 flag bits) is discarded → IDLE.
    - If count >= PAR_MIN_BITS: o_eof = 1 and o_len = count.
    - Otherwise: o_err = 3 (SHORT).
  - Otherwise: push {i_bit, keep} into the 7-deep delay line. If the line was already full, pop the oldest entry; if its keep = 1, assert o_vld with o_bit = that bit and increment the bit counter.
  - If an emitted bit would make count > PAR_MAX_BITS: o_err = LONG → IDLE. That bit is not emitted.
- i_window is ignored in RECV.
- o_busy = (state != IDLE).
- Steady-state payload latency: 8 raw bit strobes plus 1 clock.
- Reset mid-frame: immediate return to IDLE, no EOF or error pulse. After reset release the next frame is fully received.

Test Plan:
- Window open, stream 0x7E, 16 bits 0xA5C3, 0x7E → one o_sof, 16 o_vld bits equal to A5C3 in order, o_eof with o_len = 16, no o_err_vld.
- Payload 0xF8 (11111000) sent stuffed as 111110000 → stuffed zero dropped, 8 bits output, o_len counts 8 (plus other bits), EOF normal.
- Window of 24 bits containing no 0x7E → o_err_vld with o_err = 1 once, one cycle after the first i_vld with i_window = 0. State returns to IDLE, o_busy = 0.
- After SOF, 7 consecutive raw ones → o_err = 2, no o_eof, no further o_vld.
- Three cases:
  - 0x7E 0x7E then 16 data bits and 0x7E → single o_sof, o_len = 16.
  - 8 data bits then 0x7E → o_err = 3 (SHORT).
  - 257 data bits with no end flag → o_err = 3 (LONG) after 256 o_vld pulses.
- Assert i_rst_n = 0 (asynchronous, mid-clock) halfway through a payload → all outputs 0 immediately. A following complete frame is received correctly.
